// File: rtl/driver_display_tempo.sv
// Multiplexed M.SS display driver for three common-anode 7-segment digits.
// Seconds are split into BCD once per frame by a repeated-subtraction FSM.
`timescale 1ns/1ps
module driver_display_tempo #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 166
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutos,
  input  logic [5:0] segundos,
  input  logic       piscar,
  output logic [2:0] anodo,
  output logic [6:0] segmentos,
  output logic       ponto
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = SEG_DASH;
    endcase
  endfunction

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic             tick;
  logic             frame_start;
  logic [BLK_W-1:0] blk_cnt;
  logic             phase;
  logic             phase_nxt;

  logic [1:0] state;
  logic [3:0] m_s;
  logic [5:0] sec_s;
  logic [5:0] rem;
  logic [2:0] tens;
  logic [6:0] dig_m;
  logic [6:0] dig_t;
  logic [6:0] dig_u;

  logic [2:0] an_sel;
  logic [6:0] seg_sel;
  logic       pt_sel;

  assign tick        = (div == DIV_LAST);
  assign frame_start = tick && (idx == 2'd2);
  assign phase_nxt   = (frame_start && blk_cnt == BLK_LAST) ? ~phase : phase;

  always_comb begin
    idx_nxt = idx;
    if (tick) idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      idx     <= 2'd0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      div   <= tick ? '0 : div + 1'b1;
      idx   <= idx_nxt;
      phase <= phase_nxt;
      if (frame_start) blk_cnt <= (blk_cnt == BLK_LAST) ? '0 : blk_cnt + 1'b1;
    end
  end

  // Conversion: snapshot at frame start, subtract tens, then commit all digits together
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      m_s   <= '0;
      sec_s <= '0;
      rem   <= '0;
      tens  <= '0;
      dig_m <= SEG_BLANK;
      dig_t <= SEG_BLANK;
      dig_u <= SEG_BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            m_s   <= minutos;
            sec_s <= segundos;
            rem   <= segundos;
            tens  <= '0;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (rem >= 6'd10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          dig_m <= (m_s <= 4'd9) ? seg_code(m_s) : SEG_DASH;
          if (sec_s <= 6'd59) begin
            dig_t <= seg_code({1'b0, tens});
            dig_u <= seg_code(rem[3:0]);
          end else begin
            dig_t <= SEG_DASH;
            dig_u <= SEG_DASH;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (idx_nxt)
      2'd0:    begin an_sel = 3'b011; seg_sel = dig_m; pt_sel = 1'b0; end
      2'd1:    begin an_sel = 3'b101; seg_sel = dig_t; pt_sel = 1'b1; end
      default: begin an_sel = 3'b110; seg_sel = dig_u; pt_sel = 1'b1; end
    endcase
    if (piscar && phase_nxt) begin
      an_sel = 3'b111;
      pt_sel = 1'b1;
    end
  end

  // Output registers load only on a scan tick, so a digit slot never changes mid-slot
  always_ff @(posedge clk) begin
    if (rst) begin
      anodo     <= 3'b111;
      segmentos <= SEG_BLANK;
      ponto     <= 1'b1;
    end else if (tick) begin
      anodo     <= an_sel;
      segmentos <= seg_sel;
      ponto     <= pt_sel;
    end
  end

endmodule

// File: tb/tb_driver_display_tempo.sv
// Directed bench for driver_display_tempo with REFRESH_DIV=8 and BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_driver_display_tempo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] minutos;
  logic [5:0] segundos;
  logic       piscar;
  logic [2:0] anodo;
  logic [6:0] segmentos;
  logic       ponto;

  int checks = 0;
  int errors = 0;

  driver_display_tempo #(.REFRESH_DIV(8), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .minutos(minutos), .segundos(segundos),
    .piscar(piscar), .anodo(anodo), .segmentos(segmentos), .ponto(ponto)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m;
    logic [5:0] s;
    logic [6:0] em;
    logic [6:0] et;
    logic [6:0] eu;
  } vec_t;

  vec_t vecs[8];
  logic dark[8];

  task automatic check_slot(input string name, input logic [2:0] ea,
                            input logic [6:0] es, input logic ep);
    checks++;
    if ({anodo, segmentos, ponto} !== {ea, es, ep}) begin
      errors++;
      $display("FAIL %s: got anodo=%b seg=%h ponto=%b, expected anodo=%b seg=%h ponto=%b",
               name, anodo, segmentos, ponto, ea, es, ep);
    end
  endtask

  // Entered just after a frame start; returns just after the next one.
  task automatic check_frame(input string name, input logic [6:0] em,
                             input logic [6:0] et, input logic [6:0] eu);
    check_slot({name, "_m"}, 3'b011, em, 1'b0);
    repeat (8) @(negedge clk);
    check_slot({name, "_t"}, 3'b101, et, 1'b1);
    repeat (8) @(negedge clk);
    check_slot({name, "_u"}, 3'b110, eu, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_first_tick(input string name);
    bit found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (anodo != 3'b111) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: anodo stayed %b, expected a scan tick within 50 cycles", name, anodo);
    end
  endtask

  task automatic sync_frame(input string name);
    bit found = 1'b0;
    logic [2:0] prev;
    prev = anodo;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (anodo == 3'b011 && prev != 3'b011) found = 1'b1;
      prev = anodo;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: anodo=%b, expected entry into slot 011 within 200 cycles", name, anodo);
    end
  endtask

  initial begin
    vecs[0] = '{4'd9,  6'd59, 7'h10, 7'h12, 7'h10};
    vecs[1] = '{4'd0,  6'd7,  7'h40, 7'h40, 7'h78};
    vecs[2] = '{4'd12, 6'd63, 7'h3F, 7'h3F, 7'h3F};
    vecs[3] = '{4'd12, 6'd59, 7'h3F, 7'h12, 7'h10};
    vecs[4] = '{4'd5,  6'd0,  7'h12, 7'h40, 7'h40};
    vecs[5] = '{4'd3,  6'd42, 7'h30, 7'h19, 7'h24};
    vecs[6] = '{4'd8,  6'd16, 7'h00, 7'h79, 7'h02};
    vecs[7] = '{4'd1,  6'd60, 7'h79, 7'h3F, 7'h3F};

    rst = 1'b1; minutos = 4'd0; segundos = 6'd0; piscar = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_slot("reset", 3'b111, 7'h7F, 1'b1);
    rst = 1'b0;

    // Blank registers are shown until the first commit
    wait_first_tick("first_tick");
    check_slot("blank_t", 3'b101, 7'h7F, 1'b1);
    repeat (8) @(negedge clk);
    check_slot("blank_u", 3'b110, 7'h7F, 1'b1);
    repeat (8) @(negedge clk);
    check_slot("blank_m", 3'b011, 7'h7F, 1'b0);

    for (int i = 0; i < 8; i++) begin
      minutos = vecs[i].m;
      segundos = vecs[i].s;
      repeat (48) @(negedge clk);
      check_frame($sformatf("vec%0d", i), vecs[i].em, vecs[i].et, vecs[i].eu);
    end

    // Input change during CONV must not affect the frame already snapshotted
    minutos = 4'd0; segundos = 6'd30;
    repeat (24) @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 segundos = 6'd45;
    repeat (7) @(negedge clk);
    check_slot("snap30_t", 3'b101, 7'h30, 1'b1);
    repeat (8) @(negedge clk);
    check_slot("snap30_u", 3'b110, 7'h40, 1'b1);
    repeat (8) @(negedge clk);
    check_frame("snap45", 7'h40, 7'h19, 7'h12);

    // Blink: phase flips every second frame start
    piscar = 1'b1;
    repeat (24) @(negedge clk);
    for (int f = 0; f < 8; f++) begin
      dark[f] = (anodo == 3'b111);
      check_slot($sformatf("blink%0d", f), dark[f] ? 3'b111 : 3'b011, 7'h40, dark[f]);
      repeat (24) @(negedge clk);
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (dark[f] == dark[f+2]) begin
        errors++;
        $display("FAIL blink_period%0d: dark[%0d]=%0b dark[%0d]=%0b, expected opposite",
                 f, f, dark[f], f + 2, dark[f+2]);
      end
    end
    piscar = 1'b0;
    repeat (24) @(negedge clk);
    check_frame("unblink", 7'h40, 7'h19, 7'h12);

    // Reset in the middle of a conversion
    minutos = 4'd9; segundos = 6'd59;
    repeat (24) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_slot("rst_conv", 3'b111, 7'h7F, 1'b1);
    rst = 1'b0;
    wait_first_tick("rst_tick");
    check_slot("rst_blank_t", 3'b101, 7'h7F, 1'b1);
    repeat (8) @(negedge clk);
    check_slot("rst_blank_u", 3'b110, 7'h7F, 1'b1);
    repeat (8) @(negedge clk);
    check_slot("rst_blank_m", 3'b011, 7'h7F, 1'b0);
    repeat (24) @(negedge clk);
    check_frame("after_rst", 7'h10, 7'h12, 7'h10);

    sync_frame("sync_end");
    check_frame("final", 7'h10, 7'h12, 7'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
